// File: rtl/mcu_sample_dac.sv
// MCU sample-DAC conditioner: 8-bit unsigned port -> RC-model IIR low-pass -> volume/mute -> signed 16-bit.
// Optional DC-blocking high-pass after the IIR when MCU_SAMPLE_DCBLOCK_EN is defined.
module mcu_sample_dac #(
  parameter int FILT_DIV  = 200,
  parameter int SHIFT     = 3,
  parameter int ACT_TICKS = 4096
) (
  input  logic               CLK_32M,
  input  logic               reset,
  input  logic               ce_8m,
  input  logic [7:0]         sample_in,
  input  logic [7:0]         volume,
  input  logic               mute,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               dbg_activity
);

  localparam int CNT_W = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;
  localparam int ACT_W = $clog2(ACT_TICKS + 1);

  function automatic logic signed [15:0] sat16(input logic signed [24:0] v);
    if (v > 25'sd32767)
      return 16'sh7FFF;
    else if (v < -25'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  logic [7:0]         s_r;
  logic [7:0]         s_q;
  logic [CNT_W-1:0]   cnt;
  logic [ACT_W-1:0]   act_cnt;
  logic               tick;

  logic signed [15:0] x_p0;
  logic signed [16:0] d_p0;
  logic signed [16:0] step_p0;
  logic signed [24:0] y_sum_p0;
  logic signed [15:0] y_p0;
  logic               vld_p0;

  logic signed [15:0] gain_src;
  logic               gain_vld;
  logic signed [24:0] prod_g;
  logic signed [24:0] g_shift;

  always_ff @(posedge CLK_32M) begin
    s_r <= sample_in;
    s_q <= s_r;
  end

  assign tick = ce_8m && (cnt == CNT_W'(FILT_DIV - 1));

  // An input change and a tick in the same cycle: the reload takes priority.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      cnt     <= '0;
      act_cnt <= '0;
    end else begin
      if (ce_8m)
        cnt <= tick ? '0 : cnt + 1'b1;
      if (s_r != s_q)
        act_cnt <= ACT_W'(ACT_TICKS);
      else if (tick && (act_cnt != '0))
        act_cnt <= act_cnt - 1'b1;
    end
  end

  assign dbg_activity = (act_cnt != '0);

  // Stage p0: IIR low-pass state y, updated in the tick cycle
  assign x_p0     = {~s_r[7], s_r[6:0], 8'h00};
  assign d_p0     = 17'(x_p0) - 17'(y_p0);
  assign step_p0  = d_p0 >>> SHIFT;
  assign y_sum_p0 = 25'(y_p0) + 25'(step_p0);

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      y_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= tick;
      if (tick)
        y_p0 <= sat16(y_sum_p0);
    end
  end

`ifdef MCU_SAMPLE_DCBLOCK_EN
  // Stage p1: DC-blocking high-pass, z tracks the slow average of y
  logic signed [16:0] h_full_p1;
  logic signed [16:0] h_step_p1;
  logic signed [24:0] z_sum_p1;
  logic signed [15:0] z_p1;
  logic signed [15:0] h_p1;
  logic               vld_p1;

  assign h_full_p1 = 17'(y_p0) - 17'(z_p1);
  assign h_step_p1 = h_full_p1 >>> 10;
  assign z_sum_p1  = 25'(z_p1) + 25'(h_step_p1);

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      z_p1   <= '0;
      h_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        h_p1 <= sat16(25'(h_full_p1));
        z_p1 <= sat16(z_sum_p1);
      end
    end
  end

  assign gain_src = h_p1;
  assign gain_vld = vld_p1;
`else
  assign gain_src = y_p0;
  assign gain_vld = vld_p0;
`endif

  // Output stage: volume scaling (0x80 = unity), saturation and mute
  assign prod_g  = 25'(gain_src) * 25'($signed({1'b0, volume}));
  assign g_shift = prod_g >>> 7;

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= gain_vld;
      if (gain_vld)
        sample_out <= mute ? 16'sh0000 : sat16(g_shift);
    end
  end

endmodule
